// File: rtl/cpu_record_extractor_if.sv
// Char-stream and record-output bundle between the trace source/consumer and cpu_record_extractor.
interface cpu_record_extractor_if #(
  parameter int TIME_W = 14,
  parameter int CNT_W  = 16
);
  logic [7:0]        char_i;
  logic [1:0]        format_type_i;
  logic              rec_ready_i;
  logic              rec_valid_o;
  logic [1:0]        rec_type_o;
  logic [TIME_W-1:0] rec_time_o;
  logic [31:0]       rec_pc_o;
  logic [31:0]       rec_addr_o;
  logic [31:0]       rec_data_o;
  logic [CNT_W-1:0]  rec_count_o;
  logic [CNT_W-1:0]  drop_count_o;
  logic              overrun_o;

  modport master (
    output char_i, format_type_i, rec_ready_i,
    input  rec_valid_o, rec_type_o, rec_time_o, rec_pc_o, rec_addr_o, rec_data_o,
           rec_count_o, drop_count_o, overrun_o
  );

  modport slave (
    input  char_i, format_type_i, rec_ready_i,
    output rec_valid_o, rec_type_o, rec_time_o, rec_pc_o, rec_addr_o, rec_data_o,
           rec_count_o, drop_count_o, overrun_o
  );
endinterface

// File: rtl/cpu_record_extractor.sv
// Decodes trace record fields from the char stream into binary and commits them on the
// checker's format_type strobe into a one-entry valid/ready output register.
//
// state   | meaning
// S_IDLE  | waiting for '^'
// S_TIME  | decimal time digits
// S_PC    | hex pc digits
// S_SEP_A | spaces before '$' or '*'
// S_REG   | decimal grf number
// S_ADDR  | hex memory address
// S_SEP_B | spaces before '<'
// S_EQ    | expecting '='
// S_SEP_C | spaces before data
// S_DATA  | hex data digits, '#' ends the record
module cpu_record_extractor #(
  parameter int TIME_W = 14,
  parameter int CNT_W  = 16
) (
  input logic                   clk,
  input logic                   reset,
  cpu_record_extractor_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_SEP_A, S_REG, S_ADDR, S_SEP_B, S_EQ, S_SEP_C, S_DATA
  } state_e;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;

  state_e            st_q, st_d;
  logic [TIME_W-1:0] time_acc_q, time_acc_d;
  logic [31:0]       pc_acc_q, pc_acc_d;
  logic [31:0]       addr_acc_q, addr_acc_d;
  logic [31:0]       data_acc_q, data_acc_d;
  logic              reg_seen_q, reg_seen_d;
  logic [TIME_W-1:0] pend_time_q, pend_time_d;
  logic [31:0]       pend_pc_q, pend_pc_d;
  logic [31:0]       pend_addr_q, pend_addr_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic              valid_q, valid_d;
  logic [1:0]        type_q, type_d;
  logic [TIME_W-1:0] otime_q, otime_d;
  logic [31:0]       opc_q, opc_d;
  logic [31:0]       oaddr_q, oaddr_d;
  logic [31:0]       odata_q, odata_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              ovr_q, ovr_d;

  logic [7:0]        c;
  logic              is_dig, is_hex;
  logic [3:0]        dig, nib;
  logic [TIME_W-1:0] time_x10;
  logic [31:0]       addr_x10;
  logic              commit;

  assign c        = bus.char_i;
  assign is_dig   = (c >= 8'h30) && (c <= 8'h39);
  assign is_hex   = is_dig || ((c >= 8'h61) && (c <= 8'h66));
  assign dig      = c[3:0];
  assign nib      = is_dig ? c[3:0] : c[3:0] + 4'd9;
  assign time_x10 = (time_acc_q << 3) + (time_acc_q << 1) + TIME_W'(dig);
  assign addr_x10 = (addr_acc_q << 3) + (addr_acc_q << 1) + {28'd0, dig};
  assign commit   = (bus.format_type_i != 2'b00);

  always_comb begin
    st_d        = st_q;
    time_acc_d  = time_acc_q;
    pc_acc_d    = pc_acc_q;
    addr_acc_d  = addr_acc_q;
    data_acc_d  = data_acc_q;
    reg_seen_d  = reg_seen_q;
    pend_time_d = pend_time_q;
    pend_pc_d   = pend_pc_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;

    if (c == CH_CARET) begin
      st_d       = S_TIME;
      time_acc_d = '0;
    end else begin
      case (st_q)
        S_IDLE: st_d = S_IDLE;
        S_TIME: begin
          if (is_dig) time_acc_d = time_x10;
          else if (c == CH_AT) begin
            st_d     = S_PC;
            pc_acc_d = '0;
          end else st_d = S_IDLE;
        end
        S_PC: begin
          if (is_hex) pc_acc_d = {pc_acc_q[27:0], nib};
          else if (c == CH_COLON) st_d = S_SEP_A;
          else st_d = S_IDLE;
        end
        S_SEP_A: begin
          if (c == CH_SP) st_d = S_SEP_A;
          else if (c == CH_DOLLAR) begin
            st_d       = S_REG;
            addr_acc_d = '0;
            reg_seen_d = 1'b0;
          end else if (c == CH_STAR) begin
            st_d       = S_ADDR;
            addr_acc_d = '0;
          end else st_d = S_IDLE;
        end
        S_REG: begin
          // a space between '$' and the first digit is padding, not the end of the number
          if (is_dig) begin
            addr_acc_d = addr_x10;
            reg_seen_d = 1'b1;
          end else if (c == CH_SP) st_d = reg_seen_q ? S_SEP_B : S_REG;
          else if (c == CH_LT) st_d = S_EQ;
          else st_d = S_IDLE;
        end
        S_ADDR: begin
          if (is_hex) addr_acc_d = {addr_acc_q[27:0], nib};
          else if (c == CH_SP) st_d = S_SEP_B;
          else if (c == CH_LT) st_d = S_EQ;
          else st_d = S_IDLE;
        end
        S_SEP_B: begin
          if (c == CH_SP) st_d = S_SEP_B;
          else if (c == CH_LT) st_d = S_EQ;
          else st_d = S_IDLE;
        end
        S_EQ: st_d = (c == CH_EQ) ? S_SEP_C : S_IDLE;
        S_SEP_C: begin
          if (c == CH_SP) st_d = S_SEP_C;
          else if (is_hex) begin
            st_d       = S_DATA;
            data_acc_d = {28'd0, nib};
          end else st_d = S_IDLE;
        end
        S_DATA: begin
          if (is_hex) data_acc_d = {data_acc_q[27:0], nib};
          else if (c == CH_HASH) begin
            st_d        = S_IDLE;
            pend_time_d = time_acc_q;
            pend_pc_d   = pc_acc_q;
            pend_addr_d = addr_acc_q;
            pend_data_d = data_acc_q;
          end else st_d = S_IDLE;
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  // commit reads the pending bank as it stood before this edge's '#', if any
  always_comb begin
    valid_d = valid_q;
    type_d  = type_q;
    otime_d = otime_q;
    opc_d   = opc_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    count_d = count_q;
    drop_d  = drop_q;
    ovr_d   = ovr_q;

    if (commit) begin
      if (!valid_q || bus.rec_ready_i) begin
        valid_d = 1'b1;
        type_d  = bus.format_type_i;
        otime_d = pend_time_q;
        opc_d   = pend_pc_q;
        oaddr_d = pend_addr_q;
        odata_d = pend_data_q;
        count_d = count_q + CNT_W'(1);
      end else begin
        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.rec_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= S_IDLE;
      time_acc_q  <= '0;
      pc_acc_q    <= '0;
      addr_acc_q  <= '0;
      data_acc_q  <= '0;
      reg_seen_q  <= 1'b0;
      pend_time_q <= '0;
      pend_pc_q   <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      valid_q     <= 1'b0;
      type_q      <= '0;
      otime_q     <= '0;
      opc_q       <= '0;
      oaddr_q     <= '0;
      odata_q     <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      ovr_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      time_acc_q  <= time_acc_d;
      pc_acc_q    <= pc_acc_d;
      addr_acc_q  <= addr_acc_d;
      data_acc_q  <= data_acc_d;
      reg_seen_q  <= reg_seen_d;
      pend_time_q <= pend_time_d;
      pend_pc_q   <= pend_pc_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      valid_q     <= valid_d;
      type_q      <= type_d;
      otime_q     <= otime_d;
      opc_q       <= opc_d;
      oaddr_q     <= oaddr_d;
      odata_q     <= odata_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.rec_valid_o  = valid_q;
  assign bus.rec_type_o   = type_q;
  assign bus.rec_time_o   = otime_q;
  assign bus.rec_pc_o     = opc_q;
  assign bus.rec_addr_o   = oaddr_q;
  assign bus.rec_data_o   = odata_q;
  assign bus.rec_count_o  = count_q;
  assign bus.drop_count_o = drop_q;
  assign bus.overrun_o    = ovr_q;

endmodule

// File: tb/tb_cpu_record_extractor.sv
// Bench for cpu_record_extractor: directed record scenarios plus randomized records checked
// against a record-level model (field values known at generation, output slot, counters).
module tb_cpu_record_extractor;
  localparam int TIME_W = 14;
  localparam int CNT_W  = 16;
  localparam int SNAP_W = 1 + 2 + TIME_W + 96 + 2 * CNT_W + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cpu_record_extractor_if #(.TIME_W(TIME_W), .CNT_W(CNT_W)) bus ();
  cpu_record_extractor #(.TIME_W(TIME_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  logic rdy    = 1'b0;

  // model: output slot, counters, pending bank, staged fields of the record being sent
  logic              m_valid;
  logic [1:0]        m_type;
  logic [TIME_W-1:0] m_time, p_time, s_time;
  logic [31:0]       m_pc, m_addr, m_data, p_pc, p_addr, p_data, s_pc, s_addr, s_data;
  logic [CNT_W-1:0]  m_count, m_drop;
  logic              m_ovr;

  function automatic logic [SNAP_W-1:0] dut_snap();
    return {bus.rec_valid_o, bus.rec_type_o, bus.rec_time_o, bus.rec_pc_o, bus.rec_addr_o,
            bus.rec_data_o, bus.rec_count_o, bus.drop_count_o, bus.overrun_o};
  endfunction

  function automatic logic [SNAP_W-1:0] model_snap();
    return {m_valid, m_type, m_time, m_pc, m_addr, m_data, m_count, m_drop, m_ovr};
  endfunction

  function automatic string spaces(int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, " "};
    return s;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_type = 0; m_time = 0; m_pc = 0; m_addr = 0; m_data = 0;
    m_count = 0; m_drop = 0; m_ovr = 0;
    p_time = 0; p_pc = 0; p_addr = 0; p_data = 0;
  endtask

  task automatic stage(int unsigned t, logic [31:0] pc, logic [31:0] addr, logic [31:0] data);
    s_time = TIME_W'(t % (1 << TIME_W));
    s_pc = pc; s_addr = addr; s_data = data;
  endtask

  // drive one char/format_type pair for the coming edge and advance the model across that edge
  task automatic tick(byte c, logic [1:0] fmt);
    @(negedge clk);
    bus.char_i        = c;
    bus.format_type_i = fmt;
    bus.rec_ready_i   = rdy;
    if (fmt != 2'b00) begin
      if (!m_valid || rdy) begin
        m_valid = 1; m_type = fmt; m_time = p_time; m_pc = p_pc; m_addr = p_addr; m_data = p_data;
        m_count = m_count + 1'b1;
      end else begin
        if (m_drop != {CNT_W{1'b1}}) m_drop = m_drop + 1'b1;
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (c == 8'h23) begin
      p_time = s_time; p_pc = s_pc; p_addr = s_addr; p_data = s_data;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chars(string s);
    for (int i = 0; i < s.len(); i++) tick(s[i], 2'b00);
  endtask

  task automatic commit_tick(logic [1:0] typ, logic rdy_c);
    logic saved;
    saved = rdy;
    rdy = rdy_c;
    tick(8'h20, typ);
    rdy = saved;
    settle();
  endtask

  task automatic drain();
    rdy = 1;
    tick(8'h20, 2'b00);
    settle();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dut_snap() !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", dut_snap());
    end
    @(negedge clk); #2 reset = 1;
    settle();
    checks++;
    if (dut_snap() !== model_snap()) begin
      failures++; $display("FAIL reset_release: got %h expected %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_grf();
    rdy = 1;
    stage(10, 32'h3000, 5, 32'ha);
    send_chars("^10@00003000: $ 5 <= 0000000a#");
    settle();
    checks++;
    if (bus.rec_valid_o !== 1'b0) begin
      failures++; $display("FAIL grf_valid_early: got %0b expected 0", bus.rec_valid_o);
    end
    commit_tick(2'b01, 1'b1);
    checks++;
    if (bus.rec_valid_o !== 1'b1) begin
      failures++; $display("FAIL grf_valid: got %0b expected 1", bus.rec_valid_o);
    end
    checks++;
    if ({bus.rec_type_o, bus.rec_time_o, bus.rec_pc_o, bus.rec_addr_o, bus.rec_data_o}
        !== {2'b01, 14'd10, 32'h3000, 32'd5, 32'ha}) begin
      failures++;
      $display("FAIL grf_fields: got type=%0h time=%0d pc=%h addr=%0d data=%h expected 1/10/3000/5/a",
               bus.rec_type_o, bus.rec_time_o, bus.rec_pc_o, bus.rec_addr_o, bus.rec_data_o);
    end
    checks++;
    if (bus.rec_count_o !== 16'd1) begin
      failures++; $display("FAIL grf_count: got %0d expected 1", bus.rec_count_o);
    end
    drain();
    checks++;
    if (bus.rec_valid_o !== 1'b0 || bus.rec_time_o !== 14'd10) begin
      failures++; $display("FAIL grf_consume: got valid=%0b time=%0d expected 0/10",
                           bus.rec_valid_o, bus.rec_time_o);
    end
  endtask

  task automatic test_mem();
    stage(9999, 32'h300c, 32'hff00, 32'h12345678);
    send_chars("^9999@0000300c: *0000ff00 <=12345678#");
    commit_tick(2'b10, 1'b1);
    checks++;
    if ({bus.rec_valid_o, bus.rec_type_o, bus.rec_time_o, bus.rec_pc_o, bus.rec_addr_o, bus.rec_data_o}
        !== {1'b1, 2'b10, 14'd9999, 32'h300c, 32'hff00, 32'h12345678}) begin
      failures++;
      $display("FAIL mem_fields: got v=%0b type=%0h time=%0d pc=%h addr=%h data=%h expected 1/2/9999/300c/ff00/12345678",
               bus.rec_valid_o, bus.rec_type_o, bus.rec_time_o, bus.rec_pc_o, bus.rec_addr_o, bus.rec_data_o);
    end
    drain();
  endtask

  task automatic test_partial();
    logic [CNT_W-1:0] cnt0;
    cnt0 = bus.rec_count_o;
    send_chars("^5@0000300:");
    for (int i = 0; i < 3; i++) tick(8'h20, 2'b00);
    settle();
    checks++;
    if (bus.rec_valid_o !== 1'b0 || bus.rec_count_o !== cnt0) begin
      failures++; $display("FAIL partial_no_commit: got valid=%0b count=%0d expected 0/%0d",
                           bus.rec_valid_o, bus.rec_count_o, cnt0);
    end
    stage(77, 32'habc, 31, 32'hdeadbeef);
    send_chars("^77@00000abc: $ 31 <= deadbeef#");
    commit_tick(2'b01, 1'b1);
    checks++;
    if ({bus.rec_time_o, bus.rec_pc_o, bus.rec_addr_o, bus.rec_data_o}
        !== {14'd77, 32'habc, 32'd31, 32'hdeadbeef}) begin
      failures++; $display("FAIL partial_next: got time=%0d pc=%h addr=%0d data=%h expected 77/abc/31/deadbeef",
                           bus.rec_time_o, bus.rec_pc_o, bus.rec_addr_o, bus.rec_data_o);
    end
    drain();
  endtask

  task automatic test_overrun();
    rdy = 0;
    stage(1, 32'h10, 2, 32'h3);
    send_chars("^1@00000010: $ 2 <= 00000003#");
    commit_tick(2'b01, 1'b0);
    stage(4, 32'h20, 32'h50, 32'h6);
    send_chars("^4@00000020: *00000050 <= 00000006#");
    commit_tick(2'b10, 1'b0);
    checks++;
    if ({bus.rec_valid_o, bus.rec_type_o, bus.rec_addr_o, bus.rec_data_o} !== {1'b1, 2'b01, 32'd2, 32'h3}) begin
      failures++; $display("FAIL overrun_held: got v=%0b type=%0h addr=%0h data=%h expected 1/1/2/3",
                           bus.rec_valid_o, bus.rec_type_o, bus.rec_addr_o, bus.rec_data_o);
    end
    checks++;
    if (bus.drop_count_o !== 16'd1 || bus.overrun_o !== 1'b1) begin
      failures++; $display("FAIL overrun_flags: got drop=%0d ovr=%0b expected 1/1",
                           bus.drop_count_o, bus.overrun_o);
    end
    checks++;
    if (dut_snap() !== model_snap()) begin
      failures++; $display("FAIL overrun_model: got %h expected %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] cnt0;
    cnt0 = bus.rec_count_o;
    rdy = 0;
    stage(7, 32'h30, 8, 32'h9);
    send_chars("^7@00000030: $ 8 <= 00000009#");
    commit_tick(2'b01, 1'b1);
    checks++;
    if (bus.rec_valid_o !== 1'b1 || bus.rec_data_o !== 32'h9 || bus.rec_count_o !== cnt0 + 1'b1) begin
      failures++; $display("FAIL b2b_load: got v=%0b data=%h count=%0d expected 1/9/%0d",
                           bus.rec_valid_o, bus.rec_data_o, bus.rec_count_o, cnt0 + 1'b1);
    end
    drain();
    checks++;
    if (dut_snap() !== model_snap()) begin
      failures++; $display("FAIL b2b_model: got %h expected %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [1:0]  typ;
      int unsigned t;
      logic [31:0] pc, addr, data;
      string s;
      typ  = 2'($urandom_range(1, 2));
      t    = $urandom_range(0, 99999);
      pc   = $urandom;
      data = $urandom;
      if (typ == 2'b01) begin
        addr = $urandom_range(0, 4000);
        s = $sformatf("^%0d@%0h:%s$%s%0d%s<=%s%0h#", t, pc, spaces($urandom_range(0, 2)),
                      spaces($urandom_range(0, 1)), addr, spaces($urandom_range(0, 2)),
                      spaces($urandom_range(0, 2)), data);
      end else begin
        addr = $urandom;
        s = $sformatf("^%0d@%08h:%s*%0h%s<=%s%08h#", t, pc, spaces($urandom_range(0, 2)),
                      addr, spaces($urandom_range(0, 2)), spaces($urandom_range(0, 2)), data);
      end
      stage(t, pc, addr, data);
      rdy = 1'($urandom_range(0, 1));
      send_chars(s);
      commit_tick(typ, 1'($urandom_range(0, 1)));
      checks++;
      if (dut_snap() !== model_snap()) begin
        failures++; $display("FAIL random_rec%0d: got %h expected %h", n, dut_snap(), model_snap());
      end
    end
  endtask

  task automatic test_reset_mid();
    rdy = 0;
    send_chars("^123@00001234: $ 7 <= 0000");
    @(negedge clk);
    #2 reset = 0;
    #1;
    model_reset();
    checks++;
    if (dut_snap() !== '0) begin
      failures++; $display("FAIL reset_mid_outputs: got %h expected 0", dut_snap());
    end
    @(negedge clk);
    #3 reset = 1;
    tick(8'h20, 2'b01);
    settle();
    checks++;
    if ({bus.rec_valid_o, bus.rec_type_o, bus.rec_time_o, bus.rec_pc_o, bus.rec_addr_o, bus.rec_data_o,
         bus.rec_count_o} !== {1'b1, 2'b01, 14'd0, 96'd0, 16'd1}) begin
      failures++; $display("FAIL reset_mid_stale: got %h expected valid/type 1/1 with zero fields, count 1",
                           dut_snap());
    end
    checks++;
    if (dut_snap() !== model_snap()) begin
      failures++; $display("FAIL reset_mid_model: got %h expected %h", dut_snap(), model_snap());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.char_i        = 8'h20;
    bus.format_type_i = 2'b00;
    bus.rec_ready_i   = 1'b0;
    model_reset();
    s_time = 0; s_pc = 0; s_addr = 0; s_data = 0;
    test_reset();
    test_grf();
    test_mem();
    test_partial();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
